// File: rtl/base_unpack_ctrl.sv
// Unpacks words of 2-bit nucleotide codes into one ASCII character per cycle.
// Streams use valid/ready on both sides, and a new word can load as the last base leaves.
module base_unpack_ctrl #(
  parameter int WORD_W = 32,
  parameter int CNT_W  = $clog2(WORD_W/2),
  parameter int TOT_W  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_data,
  input  logic [CNT_W-1:0]  in_count,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [7:0]        out_char,
  output logic              out_last,
  output logic              frame_done,
  output logic [TOT_W-1:0]  total_bases
);

  localparam int BASES = WORD_W / 2;
  localparam int REM_W = $clog2(BASES + 1);

  typedef enum logic {EMPTY, DRAIN} state_e;

  state_e            state;
  logic [WORD_W-1:0] sr;
  logic [REM_W-1:0]  rem;
  logic              lst;
  logic              out_hs;
  logic              in_hs;
  logic              rem_one;
  logic [REM_W-1:0]  load_rem;

  // NOTE: every signal assigned in always_comb gets a value on every path, so no latch is inferred.
  always_comb begin
    rem_one   = (rem == REM_W'(1));
    out_valid = (state == DRAIN);
    out_last  = lst & rem_one;
    in_ready  = (state == EMPTY) | (rem_one & out_ready);
    out_hs    = out_valid & out_ready;
    in_hs     = in_valid & in_ready;
    load_rem  = (in_count == '0) ? REM_W'(BASES) : REM_W'(in_count);
    unique case (sr[WORD_W-1 -: 2])
      2'b00:   out_char = 8'h41;
      2'b01:   out_char = 8'h43;
      2'b10:   out_char = 8'h54;
      default: out_char = 8'h47;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every update sees pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= EMPTY;
      sr          <= '0;
      rem         <= '0;
      lst         <= 1'b0;
      frame_done  <= 1'b0;
      total_bases <= '0;
    end else begin
      frame_done <= out_hs & out_last;
      if (out_hs && total_bases != '1)
        total_bases <= total_bases + 1'b1;
      // A load wins over the shift; it can only coincide with the final base leaving.
      if (in_hs) begin
        state <= DRAIN;
        sr    <= in_data;
        rem   <= load_rem;
        lst   <= in_last;
      end else if (out_hs) begin
        sr  <= {sr[WORD_W-3:0], 2'b00};
        rem <= rem - 1'b1;
        if (rem_one)
          state <= EMPTY;
      end
    end
  end

endmodule

// File: tb/tb_base_unpack_ctrl.sv
// Randomized bench for base_unpack_ctrl checked against a queue-based model of the decoded stream.
// A second instance with a 4-bit counter shares all stimulus to exercise saturation.
module tb_base_unpack_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = '0;
  logic [3:0]  in_count = '0;
  logic        in_last = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [7:0]  out_char;
  logic        out_last;
  logic        frame_done;
  logic [31:0] total_bases;

  logic        s_in_ready, s_out_valid, s_out_last, s_frame_done;
  logic [7:0]  s_out_char;
  logic [3:0]  s_total;

  int checks = 0;
  int errors = 0;

  logic [7:0] q_char[$];
  bit         q_last[$];
  bit         fd_exp = 0;
  longint     tot = 0;
  bit         accepted;

  always #5 clk = ~clk;

  base_unpack_ctrl dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_count(in_count), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_char(out_char),
    .out_last(out_last), .frame_done(frame_done), .total_bases(total_bases)
  );

  base_unpack_ctrl #(.TOT_W(4)) dut_small (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(s_in_ready),
    .in_data(in_data), .in_count(in_count), .in_last(in_last),
    .out_valid(s_out_valid), .out_ready(out_ready), .out_char(s_out_char),
    .out_last(s_out_last), .frame_done(s_frame_done), .total_bases(s_total)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] decode(input logic [1:0] code);
    case (code)
      2'b00:   return 8'h41;
      2'b01:   return 8'h43;
      2'b10:   return 8'h54;
      default: return 8'h47;
    endcase
  endfunction

  // One clock cycle: drive, check against the model, then advance the model past the edge.
  task automatic step(input bit rv, input bit iv, input logic [31:0] d, input logic [3:0] c,
                      input bit l, input bit ordy);
    bit exp_rdy, ohs, ihs;
    int n;
    @(negedge clk);
    rst_n = rv; in_valid = iv; in_data = d; in_count = c; in_last = l; out_ready = ordy;
    #1;
    exp_rdy = (q_char.size() == 0) || (q_char.size() == 1 && ordy);
    check("out_valid", {31'd0, out_valid}, {31'd0, q_char.size() != 0});
    check("in_ready", {31'd0, in_ready}, {31'd0, exp_rdy});
    if (q_char.size() != 0) begin
      check("out_char", {24'd0, out_char}, {24'd0, q_char[0]});
      check("out_last", {31'd0, out_last}, {31'd0, q_last[0]});
    end
    check("frame_done", {31'd0, frame_done}, {31'd0, fd_exp});
    check("total_bases", total_bases, 32'(tot));
    check("total_sat4", {28'd0, s_total}, 32'(tot > 15 ? 15 : tot));
    ohs = (q_char.size() != 0) && ordy;
    ihs = iv && exp_rdy;
    accepted = rv && ihs;
    if (!rv) begin
      q_char.delete(); q_last.delete(); fd_exp = 0; tot = 0;
    end else begin
      fd_exp = ohs && q_last[0];
      if (ohs) begin
        void'(q_char.pop_front()); void'(q_last.pop_front()); tot++;
      end
      if (ihs) begin
        n = (c == 0) ? 16 : int'(c);
        for (int i = 0; i < n; i++) begin
          q_char.push_back(decode(2'((d >> (30 - 2*i)) & 32'h3)));
          q_last.push_back(l && (i == n - 1));
        end
      end
    end
  endtask

  task automatic idle(input bit ordy);
    step(1, 0, 32'h0, 4'h0, 0, ordy);
  endtask

  // Hold a word on the input until it is taken, like the upstream FIFO does.
  task automatic offer(input logic [31:0] d, input logic [3:0] c, input bit l, input int stall);
    int guard = 0;
    accepted = 0;
    while (!accepted && guard < 200) begin
      step(1, 1, d, c, l, $urandom_range(99) >= stall);
      guard++;
    end
    if (!accepted) check("offer_timeout", 0, 1);
  endtask

  task automatic drain(input int stall);
    int guard = 0;
    while (q_char.size() != 0 && guard < 400) begin
      idle($urandom_range(99) >= stall);
      guard++;
    end
    if (q_char.size() != 0) check("drain_timeout", 0, 1);
    idle(1);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    idle(1);
    idle(0);

    // Single 4-base frame: A C T G, frame_done after the last one.
    offer(32'h1B000000, 4'd4, 1, 0);
    for (int i = 0; i < 4; i++) idle(1);
    idle(1);
    check("t1_total", total_bases, 32'd4);

    // Two full words back to back with no gap.
    offer(32'hFFFFFFFF, 4'd0, 0, 0);
    offer(32'h00000000, 4'd0, 1, 0);
    drain(0);

    // Stalling downstream.
    offer(32'h1B000000, 4'd4, 1, 0);
    drain(50);

    // Reset after two of four bases.
    offer(32'h1B000000, 4'd4, 1, 0);
    idle(1);
    idle(1);
    step(0, 0, 32'h0, 4'h0, 0, 1);
    idle(1);
    check("rst_total", total_bases, 32'd0);
    offer(32'h1B000000, 4'd4, 1, 0);
    drain(0);

    // One-base word followed immediately by a waiting word.
    offer(32'h80000000, 4'd1, 0, 0);
    offer(32'hE4000000, 4'd0, 1, 0);
    drain(0);

    // Random traffic.
    for (int w = 0; w < 300; w++) begin
      int st = (w % 3 == 0) ? 0 : int'($urandom_range(60));
      offer($urandom, 4'($urandom_range(15)), $urandom_range(3) == 0, st);
      if ($urandom_range(4) == 0) drain(st);
      if ($urandom_range(9) == 0) idle($urandom_range(1) == 1);
    end
    drain(0);
    check("sat4_final", {28'd0, s_total}, 32'hF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
